// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants (640x480@60 defaults), coordinate width and the
// registered sync bundle used by vga_sync_gen.
package vga_timing_pkg;

    localparam int COORD_W   = 10;
    localparam int COORD_MAX = 1 << COORD_W;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam int DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic video_on;
    } sync_t;

    // (0,0) is visible, so the undelayed flags come out of reset with video_on high.
    localparam sync_t SYNC_RST       = '{hsync: 1'b1, vsync: 1'b1, video_on: 1'b1};
    localparam sync_t SYNC_ALIGN_RST = '{hsync: 1'b1, vsync: 1'b1, video_on: 1'b0};

    function automatic logic in_window(input logic [COORD_W-1:0] val,
                                       input logic [COORD_W-1:0] lo,
                                       input logic [COORD_W-1:0] hi);
        return (val >= lo) && (val <= hi);
    endfunction

endpackage

// File: rtl/pixel_tick_gen.sv
// Divides the system clock into a one-clk pixel enable every CLK_DIV clocks.
// With CLK_DIV=1 the counter sits at 0 and the enable is permanently high.
module pixel_tick_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic pixel_tick
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    if (CLK_DIV < 1) begin : g_div_chk
        $error("pixel_tick_gen: CLK_DIV must be at least 1");
    end

    logic [DIV_W-1:0] div_cnt_q;
    logic [DIV_W-1:0] div_cnt_d;
    logic             at_last;

    assign at_last = (div_cnt_q == DIV_LAST);

    always_comb begin
        div_cnt_d = div_cnt_q + 1'b1;
        if (at_last) begin
            div_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

    // Decoded from the register so the tick is glitch-free and 0 in reset.
    assign pixel_tick = at_last;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel coordinates, active-low syncs, blanking flag and
// frame tick. Define VGA_SYNC_ALIGN_EN to delay hsync/vsync/video_on by 2 clks.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [COORD_W-1:0] H_Coord,
    output logic [COORD_W-1:0] V_Coord,
    output logic               hsync,
    output logic               vsync,
    output logic               video_on,
    output logic               pixel_tick,
    output logic               frame_tick
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (H_TOTAL > COORD_MAX) begin : g_h_total_chk
        $error("vga_sync_gen: H_TOTAL exceeds the coordinate range");
    end
    if (V_TOTAL > COORD_MAX) begin : g_v_total_chk
        $error("vga_sync_gen: V_TOTAL exceeds the coordinate range");
    end

    localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
    localparam logic [COORD_W-1:0] H_VIS    = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] V_VIS    = COORD_W'(V_ACTIVE);
    localparam logic [COORD_W-1:0] HS_FIRST = COORD_W'(H_ACTIVE + H_FP);
    localparam logic [COORD_W-1:0] HS_LAST  = COORD_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [COORD_W-1:0] VS_FIRST = COORD_W'(V_ACTIVE + V_FP);
    localparam logic [COORD_W-1:0] VS_LAST  = COORD_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic               tick;
    logic [COORD_W-1:0] h_q, h_d;
    logic [COORD_W-1:0] v_q, v_d;
    logic               h_last, v_last;
    sync_t              sync_q, sync_d;
    logic               frame_q, frame_d;
    sync_t              sync_out;

    pixel_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_pixel_tick_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .pixel_tick (tick)
    );

    assign h_last = (h_q == H_LAST);
    assign v_last = (v_q == V_LAST);

    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (tick) begin
            if (h_last) begin
                h_d = '0;
                v_d = v_last ? '0 : v_q + 1'b1;
            end else begin
                h_d = h_q + 1'b1;
            end
        end
    end

    // Decoding the next coordinates keeps the registered flags in step with H/V.
    always_comb begin
        sync_d.hsync    = ~in_window(h_d, HS_FIRST, HS_LAST);
        sync_d.vsync    = ~in_window(v_d, VS_FIRST, VS_LAST);
        sync_d.video_on = (h_d < H_VIS) && (v_d < V_VIS);
        frame_d         = tick && h_last && v_last;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_q     <= '0;
            v_q     <= '0;
            sync_q  <= SYNC_RST;
            frame_q <= 1'b0;
        end else begin
            h_q     <= h_d;
            v_q     <= v_d;
            sync_q  <= sync_d;
            frame_q <= frame_d;
        end
    end

`ifdef VGA_SYNC_ALIGN_EN
    // Two stages to match the score renderer's pixel pipeline.
    sync_t sync_dly1_q;
    sync_t sync_dly2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_dly1_q <= SYNC_ALIGN_RST;
            sync_dly2_q <= SYNC_ALIGN_RST;
        end else begin
            sync_dly1_q <= sync_q;
            sync_dly2_q <= sync_dly1_q;
        end
    end

    assign sync_out = sync_dly2_q;
`else
    assign sync_out = sync_q;
`endif

    assign H_Coord    = h_q;
    assign V_Coord    = v_q;
    assign hsync      = sync_out.hsync;
    assign vsync      = sync_out.vsync;
    assign video_on   = sync_out.video_on;
    assign pixel_tick = tick;
    assign frame_tick = frame_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Self-checking bench for vga_sync_gen: a CLK_DIV=2 and a CLK_DIV=1 instance
// with reduced timing, checked each clk against a model derived from elapsed clks.
module tb_vga_sync_gen;

  localparam int HA = 64;
  localparam int HF = 4;
  localparam int HS = 8;
  localparam int HB = 4;
  localparam int VA = 20;
  localparam int VF = 2;
  localparam int VS = 2;
  localparam int VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [9:0] h2, v2, h1, v1;
  logic hs2, vs2, von2, pt2, ft2;
  logic hs1, vs1, von1, pt1, ft1;

  int n;
  int checks;
  int failures;
  logic [24:0] exp2_q[$];
  logic [24:0] exp1_q[$];
  logic [24:0] got, e;

  always #5 clk = ~clk;

  vga_sync_gen #(
    .CLK_DIV(2), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .H_Coord(h2), .V_Coord(v2), .hsync(hs2),
    .vsync(vs2), .video_on(von2), .pixel_tick(pt2), .frame_tick(ft2)
  );

  vga_sync_gen #(
    .CLK_DIV(1), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .H_Coord(h1), .V_Coord(v1), .hsync(hs1),
    .vsync(vs1), .video_on(von1), .pixel_tick(pt1), .frame_tick(ft1)
  );

  // {hsync, vsync, video_on} for the pixel reached after k clks of counting.
  function automatic logic [2:0] sync_at(int k, int div);
    int pix = k / div;
    int h = pix % HT;
    int v = (pix / HT) % VT;
    logic hs_b = !((h >= HA + HF) && (h < HA + HF + HS));
    logic vs_b = !((v >= VA + VF) && (v < VA + VF + VS));
    logic von_b = (h < HA) && (v < VA);
    return {hs_b, vs_b, von_b};
  endfunction

  function automatic logic [24:0] model(int k, int div);
    int pix = k / div;
    int h = pix % HT;
    int v = (pix / HT) % VT;
    logic [2:0] s;
    logic pt_b = ((k % div) == (div - 1));
    logic ft_b = (k != 0) && ((k % (HT * VT * div)) == 0);
`ifdef VGA_SYNC_ALIGN_EN
    s = (k >= 2) ? sync_at(k - 2, div) : 3'b110;
`else
    s = sync_at(k, div);
`endif
    return {10'(h), 10'(v), s, pt_b, ft_b};
  endfunction

  // One clk: count it, queue the expected outputs, then move to the sample point.
  task automatic advance();
    @(posedge clk);
    if (rst_n) n++;
    else n = 0;
    exp2_q.push_back(model(n, 2));
    exp1_q.push_back(model(n, 1));
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      advance();
      got = {h2, v2, hs2, vs2, von2, pt2, ft2};
      e = exp2_q.pop_front();
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL reset_div2 n=%0d got=%h exp=%h", n, got, e);
      end
      got = {h1, v1, hs1, vs1, von1, pt1, ft1};
      e = exp1_q.pop_front();
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL reset_div1 n=%0d got=%h exp=%h", n, got, e);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_line();
    int hs_low = 0;
    for (int i = 0; i < HT * 2 + 6; i++) begin
      advance();
      if (!hs2) hs_low++;
      got = {h2, v2, hs2, vs2, von2, pt2, ft2};
      e = exp2_q.pop_front();
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL line_div2 n=%0d got=%h exp=%h", n, got, e);
      end
      got = {h1, v1, hs1, vs1, von1, pt1, ft1};
      e = exp1_q.pop_front();
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL line_div1 n=%0d got=%h exp=%h", n, got, e);
      end
    end
    checks++;
    if (hs_low != HS * 2) begin
      failures++;
      $display("FAIL hsync_width got=%0d exp=%0d", hs_low, HS * 2);
    end
  endtask

  task automatic test_frame();
    int ticks = 0;
    int tick_n = -1;
    int vs_low = 0;
    while (n < HT * VT * 2 + 4) begin
      advance();
      if (ft2) begin
        ticks++;
        tick_n = n;
      end
      if (!vs2) vs_low++;
      got = {h2, v2, hs2, vs2, von2, pt2, ft2};
      e = exp2_q.pop_front();
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL frame_div2 n=%0d got=%h exp=%h", n, got, e);
      end
      got = {h1, v1, hs1, vs1, von1, pt1, ft1};
      e = exp1_q.pop_front();
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL frame_div1 n=%0d got=%h exp=%h", n, got, e);
      end
    end
    checks++;
    if (ticks != 1 || tick_n != HT * VT * 2) begin
      failures++;
      $display("FAIL frame_tick_count got=%0d@%0d exp=1@%0d", ticks, tick_n, HT * VT * 2);
    end
    checks++;
    if (vs_low != VS * HT * 2) begin
      failures++;
      $display("FAIL vsync_width got=%0d exp=%0d", vs_low, VS * HT * 2);
    end
  endtask

  task automatic test_async_reset();
    int target = HT * VT * 2 + (10 * HT + 30) * 2;
    while (n < target) begin
      advance();
      got = {h2, v2, hs2, vs2, von2, pt2, ft2};
      e = exp2_q.pop_front();
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL pre_reset_div2 n=%0d got=%h exp=%h", n, got, e);
      end
      void'(exp1_q.pop_front());
    end
    checks++;
    if (h2 !== 10'd30 || v2 !== 10'd10) begin
      failures++;
      $display("FAIL pre_reset_coord got=%0d,%0d exp=30,10", h2, v2);
    end
    #2 rst_n = 1'b0;
    exp2_q.push_back(model(0, 2));
    exp1_q.push_back(model(0, 1));
    #1;
    got = {h2, v2, hs2, vs2, von2, pt2, ft2};
    e = exp2_q.pop_front();
    checks++;
    if (got !== e) begin
      failures++;
      $display("FAIL async_reset_div2 got=%h exp=%h", got, e);
    end
    got = {h1, v1, hs1, vs1, von1, pt1, ft1};
    e = exp1_q.pop_front();
    checks++;
    if (got !== e) begin
      failures++;
      $display("FAIL async_reset_div1 got=%h exp=%h", got, e);
    end
    n = 0;
    test_reset();
    for (int i = 0; i < 12; i++) begin
      advance();
      got = {h2, v2, hs2, vs2, von2, pt2, ft2};
      e = exp2_q.pop_front();
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL restart_div2 n=%0d got=%h exp=%h", n, got, e);
      end
      void'(exp1_q.pop_front());
    end
  endtask

  task automatic test_clkdiv1();
    int ticks = 0;
    int first_n = -1;
    int second_n = -1;
    int pt_low = 0;
    int start = n;
    while (n < start + HT * VT * 2 + 2) begin
      advance();
      if (!pt1) pt_low++;
      if (ft1) begin
        ticks++;
        if (first_n < 0) first_n = n;
        else second_n = n;
      end
      got = {h1, v1, hs1, vs1, von1, pt1, ft1};
      e = exp1_q.pop_front();
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL div1_run n=%0d got=%h exp=%h", n, got, e);
      end
      void'(exp2_q.pop_front());
    end
    checks++;
    if (pt_low != 0) begin
      failures++;
      $display("FAIL div1_pixel_tick low_clks got=%0d exp=0", pt_low);
    end
    checks++;
    if (ticks != 2 || first_n != HT * VT || second_n - first_n != HT * VT) begin
      failures++;
      $display("FAIL div1_frame_len got=%0d ticks first=%0d second=%0d exp period=%0d",
               ticks, first_n, second_n, HT * VT);
    end
  endtask

  initial begin
    n = 0;
    checks = 0;
    failures = 0;
    test_reset();
    test_line();
    test_frame();
    test_async_reset();
    test_clkdiv1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

VGA 640x480@60 Hz timing generator producing the `H_Coord`/`V_Coord` pixel coordinates consumed by the score digit renderer and the other sprite/overlay renderers. It also produces the active-low `hsync`/`vsync` pulses driven to the connector. It divides the system clock into a pixel-rate enable and runs horizontal and vertical counters. It emits a `video_on` blanking flag and a once-per-frame `frame_tick` that game logic uses to step movement and scoring.

## Interface

Parameters:
- `CLK_DIV`, 2: system clocks per pixel (50 MHz clk -> 25 MHz pixel rate); must be ≥ 1.
- `H_ACTIVE`, 640: visible pixels per line.
- `H_FP`, 16: horizontal front porch, in pixels.
- `H_SYNC`, 96: horizontal sync width, in pixels.
- `H_BP`, 48: horizontal back porch, in pixels.
- `V_ACTIVE`, 480: visible lines.
- `V_FP`, 10: vertical front porch, in lines.
- `V_SYNC`, 2: vertical sync width, in lines.
- `V_BP`, 33: vertical back porch, in lines.

Ports:
- `clk`  in  1  system clock, single clock domain.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `H_Coord`  out  10  current pixel column, 0..H_TOTAL-1.
- `V_Coord`  out  10  current line, 0..V_TOTAL-1.
- `hsync`  out  1  horizontal sync, active-low.
- `vsync`  out  1  vertical sync, active-low.
- `video_on`  out  1  high while the pixel is in the visible area.
- `pixel_tick`  out  1  one-clk pulse; counters advance on the edge ending this cycle.
- `frame_tick`  out  1  one-clk pulse on the first clk of each new frame.

## Operation

- Totals: `H_TOTAL` = H_ACTIVE+H_FP+H_SYNC+H_BP = 800; `V_TOTAL` = 525. Both totals must be ≤ 1024 (10-bit coordinates); this is checked at elaboration.
- Divider `div_cnt` counts 0..CLK_DIV-1 and wraps. `pixel_tick` = (div_cnt == CLK_DIV-1), decoded from the register. With CLK_DIV=1, `pixel_tick` is constantly high.
- On a clk edge with `pixel_tick` high:
  - H increments.
  - At H_TOTAL-1, H wraps to 0 and V increments.
  - At V_TOTAL-1 with H at H_TOTAL-1, both H and V wrap to 0.
- `H_Coord`/`V_Coord` are the counter registers directly.
- `hsync`, `vsync` and `video_on` are registered. They are computed from the next counter values, so they always describe the coordinate currently on `H_Coord`/`V_Coord`:
  - `hsync` = 0 iff H ∈ [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] = [656, 751].
  - `vsync` = 0 iff V ∈ [490, 491].
  - `video_on` = (H < 640) && (V < 480).
- `frame_tick` is a registered pulse. It is high for exactly one clk, in the first clk where the counters read (0,0) after a wrap.
- Reset values: div_cnt=0, `H_Coord`=0, `V_Coord`=0, `hsync`=1, `vsync`=1, `video_on`=1, `frame_tick`=0, `pixel_tick`=0 (CLK_DIV>1).
- Releasing reset does not generate a `frame_tick`. Asserting `rst_n` mid-frame forces all registers to their reset values immediately, with no clk edge required. Counting restarts from (0,0) with the divider at 0.

## Timing

- The first `pixel_tick` occurs CLK_DIV-1 clks after reset release. `H_Coord` becomes 1 on the following edge.
- Each pixel lasts CLK_DIV clks. A line lasts 800·CLK_DIV clks. A frame lasts 420000·CLK_DIV clks (840000 at CLK_DIV=2).
- `hsync`, `vsync`, `video_on` and `frame_tick` have zero latency relative to the coordinates: they change on the same edge as the coordinates.

## Configuration

- `VGA_SYNC_ALIGN_EN` defined:
  - `hsync`, `vsync` and `video_on` pass through a 2-clk delay line. This matches the two register stages of the score renderer, so the pins line up with the renderer's pixel output.
  - Delay registers reset to 1/1/0.
  - `H_Coord`, `V_Coord`, `pixel_tick` and `frame_tick` are not delayed.
- Undefined: no delay; all outputs are aligned to the coordinates as described under Timing.

## Structure

- Shared package `vga_timing_pkg` holds:
  - the 640x480@60 default constants and the derived H_TOTAL/V_TOTAL;
  - the coordinate width constant (10).
- One sub-module, `pixel_tick_gen`: the CLK_DIV divider producing `pixel_tick`. The counters, sync decode and optional delay line stay in `vga_sync_gen`.

## Test plan

- Reset release, CLK_DIV=2 -> `pixel_tick` pulses on clks 1, 3, 5…; `H_Coord` reads 0,0,1,1,2…; `V_Coord`=0; `frame_tick`=0.
- Run one line -> after H=799, `H_Coord`=0 and `V_Coord`=1 on the same edge; `hsync` low for exactly 96 pixels (H 656..751, 192 clks).
- Run one full frame -> `vsync` low only for V=490..491; `video_on` low whenever H≥640 or V≥480; exactly one `frame_tick`, 840000 clks after the reset-release frame start, with coords (0,0).
- Assert `rst_n` asynchronously at H=300, V=200, between clk edges -> all outputs take reset values before the next edge; counting resumes from (0,0) after release.
- Build with `VGA_SYNC_ALIGN_EN` -> `hsync` falls exactly 2 clks after `H_Coord` becomes 656; `video_on` falls 2 clks after `H_Coord` becomes 640.
- CLK_DIV=1 -> `pixel_tick` constantly high; `H_Coord` increments every clk; frame length is 420000 clks.
